pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: PC width in bits.
REQ-002 SHALL provide parameter RESET_VEC, default 0: PC value after reset.
REQ-003 SHALL provide parameter EXC_VEC, default 32'h0000_0180: exception handler address.
REQ-004 SHALL provide parameter INC, default 4: sequential increment.
REQ-005 SHALL provide parameter RAS_DEPTH, default 4: return-address-stack entries; power of two, 2..16.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port freeze  input  1  hazard-unit stall; the PC holds while it is high.
REQ-009 SHALL have port redirect_valid  input  1  branch or jump resolved taken.
REQ-010 SHALL have port redirect_target  input  WIDTH  redirect destination.
REQ-011 SHALL have port exc_valid  input  1  exception request.
REQ-012 SHALL have port call  input  1  current instruction is a call.
REQ-013 SHALL have port ret  input  1  current instruction is a return.
REQ-014 SHALL have port pc  output  WIDTH  registered program counter.
REQ-015 SHALL have port pc_plus  output  WIDTH  combinational pc+INC, modulo 2^WIDTH.
REQ-016 SHALL have port redirect_pending  output  1  a redirect is held, waiting for freeze to drop.
REQ-017 SHALL have ports ras_empty and ras_full  output  1 each  return-address-stack status.

Function
REQ-018 SHALL select the next pc in this priority order, evaluated every cycle: exception, new redirect, pending redirect, freeze, RAS pop, sequential.
REQ-019 SHALL load EXC_VEC when exc_valid=1, even if freeze=1, and SHALL clear redirect_pending in that cycle.
REQ-020 SHALL load redirect_target when redirect_valid=1 and freeze=0, and SHALL clear any pending redirect (the new redirect wins).
REQ-021 SHALL latch redirect_target and set redirect_pending when redirect_valid=1 and freeze=1, and SHALL hold pc; a later redirect during the same freeze SHALL overwrite the latched target.
REQ-022 SHALL load the latched target on the first cycle with freeze=0, redirect_pending=1, redirect_valid=0 and exc_valid=0, and SHALL clear redirect_pending.
REQ-023 SHALL hold pc while freeze=1 and no exception is present.
REQ-024 SHALL otherwise load pc+INC, wrapping modulo 2^WIDTH with no flag.
REQ-025 SHALL act on call/ret only in a sequential-advance cycle; they are ignored in exception, redirect, pending or frozen cycles.
REQ-026 SHALL, on ret with ras_empty=0, load pc from the top entry and pop it; ret with ras_empty=1 SHALL advance sequentially.
REQ-027 SHALL, on call, push pc+INC and advance sequentially; a push when full SHALL overwrite the oldest entry, and ras_full stays 1.
REQ-028 SHALL, on call and ret together with the stack non-empty, load the old top and replace the top with pc+INC (occupancy unchanged); with the stack empty, this case SHALL be treated as call.
REQ-029 SHALL leave RAS contents unchanged on exceptions and redirects.

Reset
REQ-030 SHALL, while reset=0, asynchronously force pc=RESET_VEC, redirect_pending=0, RAS occupancy 0, ras_empty=1 and ras_full=0.
REQ-031 SHALL resume at the first rising clk edge after reset deasserts, producing pc=RESET_VEC+INC if there is no stall or redirect; reset mid-freeze SHALL discard any pending redirect.

Configuration
REQ-032 SHALL compile the return-address stack only when PC_UNIT_RAS_EN is defined.
REQ-033 SHALL, without PC_UNIT_RAS_EN, keep all ports, ignore call and ret, tie ras_empty=1 and ras_full=0, and instantiate no stack storage.

Verification
REQ-034 SHALL cover: reset released with freeze=0 for 3 cycles -> pc sequence 0x0, 0x4, 0x8, 0xC.
REQ-035 SHALL cover: freeze=1 with redirect 0x100 at pc 0x20, freeze held 2 cycles -> pc stays 0x20, redirect_pending=1, then pc=0x100 and pending=0.
REQ-036 SHALL cover: exc_valid together with redirect 0x200 during freeze -> pc=0x180 and pending cleared.
REQ-037 SHALL cover: WIDTH=8, pc=0xFC -> next pc=0x00.
REQ-038 SHALL cover (RAS_EN): call at 0x10, then 0x40, then ret, ret, ret -> pc 0x44, 0x14, then sequential; ras_empty=1 at the end.
REQ-039 SHALL cover (RAS_EN, RAS_DEPTH=4): five calls then five rets -> first four rets follow LIFO, fifth advances sequentially.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter with stall-aware redirect latching and exception override.
// Optional return-address stack compiled only when PC_UNIT_RAS_EN is defined.
module pc_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_0180),
  parameter int unsigned      INC       = 4,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_valid,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             redirect_pending,
  output logic             ras_empty,
  output logic             ras_full
);

  logic [WIDTH-1:0] pend_tgt;
  logic [WIDTH-1:0] seq_pc;
  logic             advance;

  assign pc_plus = pc + WIDTH'(INC);
  // Only a plain sequential-advance cycle may touch the stack.
  assign advance = !exc_valid && !redirect_valid && !redirect_pending && !freeze;

`ifdef PC_UNIT_RAS_EN
  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [WIDTH-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]    sp;
  logic [PW-1:0]    top_idx;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign top_idx   = sp - PW'(1);
  assign ras_empty = (cnt == '0);
  assign ras_full  = (cnt == (PW+1)'(RAS_DEPTH));
  assign do_push   = advance && call;
  assign do_pop    = advance && ret && !ras_empty;
  assign seq_pc    = do_pop ? stack[top_idx] : pc_plus;

  // Circular pointer: a push when full wraps onto the oldest entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp  <= '0;
      cnt <= '0;
    end else if (do_push && !do_pop) begin
      sp <= sp + PW'(1);
      if (!ras_full) cnt <= cnt + (PW+1)'(1);
    end else if (do_pop && !do_push) begin
      sp  <= top_idx;
      cnt <= cnt - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && do_pop)  stack[top_idx] <= pc_plus;
    else if (do_push)       stack[sp]      <= pc_plus;
  end
`else
  logic unused_ras;
  assign unused_ras = call ^ ret ^ advance;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
  assign seq_pc     = pc_plus;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc               <= RESET_VEC;
      pend_tgt         <= '0;
      redirect_pending <= 1'b0;
    end else if (exc_valid) begin
      pc               <= EXC_VEC;
      redirect_pending <= 1'b0;
    end else if (redirect_valid && !freeze) begin
      pc               <= redirect_target;
      redirect_pending <= 1'b0;
    end else if (redirect_valid) begin
      pend_tgt         <= redirect_target;
      redirect_pending <= 1'b1;
    end else if (redirect_pending && !freeze) begin
      pc               <= pend_tgt;
      redirect_pending <= 1'b0;
    end else if (!freeze) begin
      pc <= seq_pc;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: scoreboard of expected pc/status per cycle.
// RAS scenarios are exercised when PC_UNIT_RAS_EN is defined.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n, freeze, rv, exc, call, ret;
  logic [31:0] tgt, pc, pc_plus;
  logic        pend, emp, full;

  logic        rst8, rv8;
  logic [7:0]  tgt8, pc8, pc_plus8;
  logic        pend8, emp8, full8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        pend;
    logic        emp;
    logic        full;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .reset(rst_n), .freeze(freeze), .redirect_valid(rv),
    .redirect_target(tgt), .exc_valid(exc), .call(call), .ret(ret),
    .pc(pc), .pc_plus(pc_plus), .redirect_pending(pend),
    .ras_empty(emp), .ras_full(full)
  );

  pc_unit #(.WIDTH(8), .RESET_VEC(8'h00), .EXC_VEC(8'h80)) u8 (
    .clk(clk), .reset(rst8), .freeze(1'b0), .redirect_valid(rv8),
    .redirect_target(tgt8), .exc_valid(1'b0), .call(1'b0), .ret(1'b0),
    .pc(pc8), .pc_plus(pc_plus8), .redirect_pending(pend8),
    .ras_empty(emp8), .ras_full(full8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, record what must appear after the edge, then check it.
  task automatic step(input string tag, input logic fr, input logic rv_i,
                      input logic [31:0] tg, input logic ex, input logic cl,
                      input logic rt, input logic [31:0] epc,
                      input logic ep = 1'b0, input logic ee = 1'b1,
                      input logic ef = 1'b0);
    exp_t e;
    freeze = fr; rv = rv_i; tgt = tg; exc = ex; call = cl; ret = rt;
    sb.push_back('{tag, epc, ep, ee, ef});
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({e.tag, ".pc"},      pc,             e.pc);
    chk({e.tag, ".plus"},    pc_plus,        e.pc + 32'd4);
    chk({e.tag, ".pending"}, {31'd0, pend},  {31'd0, e.pend});
    chk({e.tag, ".empty"},   {31'd0, emp},   {31'd0, e.emp});
    chk({e.tag, ".full"},    {31'd0, full},  {31'd0, e.full});
  endtask

  initial begin
    rst_n = 1'b0; rst8 = 1'b0; rv8 = 1'b0; tgt8 = '0;
    freeze = 1'b0; rv = 1'b0; tgt = '0; exc = 1'b0; call = 1'b0; ret = 1'b0;
    #12;
    chk("rst.pc",      pc,                32'h0);
    chk("rst.pending", {31'd0, pend},     32'd0);
    chk("rst.empty",   {31'd0, emp},      32'd1);
    chk("rst.full",    {31'd0, full},     32'd0);

    // 8-bit instance: wrap from 0xFC to 0x00 while the main unit sits in reset.
    @(posedge clk); #1;
    rst8 = 1'b1; rv8 = 1'b1; tgt8 = 8'hFC;
    @(posedge clk); #1;
    chk("w8.load", {24'd0, pc8}, 32'h0000_00FC);
    rv8 = 1'b0;
    @(posedge clk); #1;
    chk("w8.wrap", {24'd0, pc8}, 32'h0000_0000);
    chk("rst.hold", pc, 32'h0);

    rst_n = 1'b1;
    step("seq0", 0, 0, 0, 0, 0, 0, 32'h4);
    step("seq1", 0, 0, 0, 0, 0, 0, 32'h8);
    step("seq2", 0, 0, 0, 0, 0, 0, 32'hC);
    for (int i = 0; i < 5; i++)
      step("seqrun", 0, 0, 0, 0, 0, 0, 32'h10 + 32'(i) * 32'd4);

    step("frz_rd",   1, 1, 32'h100, 0, 0, 0, 32'h20, 1);
    step("frz_hold", 1, 0, 0,       0, 0, 0, 32'h20, 1);
    step("pend_ld",  0, 0, 0,       0, 0, 0, 32'h100, 0);

    step("ovw_a",    1, 1, 32'h300, 0, 0, 0, 32'h100, 1);
    step("ovw_b",    1, 1, 32'h340, 0, 0, 0, 32'h100, 1);
    step("ovw_ld",   0, 0, 0,       0, 0, 0, 32'h340, 0);

    step("exc_frz",  1, 1, 32'h200, 1, 0, 0, 32'h180, 0);
    step("exc_seq",  0, 0, 0,       0, 0, 0, 32'h184, 0);
    step("pend_b",   1, 1, 32'h500, 0, 0, 0, 32'h184, 1);
    step("exc_clr",  1, 0, 0,       1, 0, 0, 32'h180, 0);
    step("exc_seq2", 0, 0, 0,       0, 0, 0, 32'h184, 0);

    step("rd",       0, 1, 32'h1000, 0, 0, 0, 32'h1000);
    step("hold",     1, 0, 0,        0, 1, 1, 32'h1000);
    step("unfrz",    0, 0, 0,        0, 0, 0, 32'h1004);
    step("pend_c",   1, 1, 32'h600,  0, 0, 0, 32'h1004, 1);
    step("new_wins", 0, 1, 32'h800,  0, 0, 0, 32'h800, 0);

`ifdef PC_UNIT_RAS_EN
    step("r_to10",  0, 1, 32'h10, 0, 0, 0, 32'h10, 0, 1, 0);
    step("r_call1", 0, 0, 0,      0, 1, 0, 32'h14, 0, 0, 0);
    step("r_to40",  0, 1, 32'h40, 0, 0, 0, 32'h40, 0, 0, 0);
    step("r_call2", 0, 0, 0,      0, 1, 0, 32'h44, 0, 0, 0);
    step("r_ret1",  0, 0, 0,      0, 0, 1, 32'h44, 0, 0, 0);
    step("r_ret2",  0, 0, 0,      0, 0, 1, 32'h14, 0, 1, 0);
    step("r_ret3",  0, 0, 0,      0, 0, 1, 32'h18, 0, 1, 0);

    step("d_to1000", 0, 1, 32'h1000, 0, 0, 0, 32'h1000, 0, 1, 0);
    for (int i = 1; i <= 5; i++)
      step("d_call", 0, 0, 0, 0, 1, 0, 32'h1000 + 32'(i) * 32'd4, 0, 0, (i >= 4));
    step("d_ret1", 0, 0, 0, 0, 0, 1, 32'h1014, 0, 0, 0);
    step("d_ret2", 0, 0, 0, 0, 0, 1, 32'h1010, 0, 0, 0);
    step("d_ret3", 0, 0, 0, 0, 0, 1, 32'h100C, 0, 0, 0);
    step("d_ret4", 0, 0, 0, 0, 0, 1, 32'h1008, 0, 1, 0);
    step("d_ret5", 0, 0, 0, 0, 0, 1, 32'h100C, 0, 1, 0);

    step("c_to2000", 0, 1, 32'h2000, 0, 0, 0, 32'h2000, 0, 1, 0);
    step("c_call",   0, 0, 0,        0, 1, 0, 32'h2004, 0, 0, 0);
    step("c_to3000", 0, 1, 32'h3000, 0, 1, 1, 32'h3000, 0, 0, 0);
    step("c_both",   0, 0, 0,        0, 1, 1, 32'h2004, 0, 0, 0);
    step("c_ret",    0, 0, 0,        0, 0, 1, 32'h3004, 0, 1, 0);
`else
    step("n_call", 0, 0, 0, 0, 1, 0, 32'h804);
    step("n_ret",  0, 0, 0, 0, 0, 1, 32'h808);
    step("n_both", 0, 0, 0, 0, 1, 1, 32'h80C);
`endif

    // Reset asserted mid-freeze with a redirect held: the target must be dropped.
    step("rf_pend", 1, 1, 32'h700, 0, 0, 0, pc, 1, emp, full);
    #2 rst_n = 1'b0;
    #1;
    chk("rf.pc",      pc,            32'h0);
    chk("rf.pending", {31'd0, pend}, 32'd0);
    chk("rf.empty",   {31'd0, emp},  32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("rf_resume", 0, 0, 0, 0, 0, 0, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
